// File: rtl/dual_sipo_shifter.sv
// dual_sipo_shifter: shared-input left/right SIPO pair with word latch and valid pulse; define SIPO_PARITY_EN to add the Par output.
module dual_sipo_shifter #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             D,
    input  logic             En,
    input  logic             Clr,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [CW-1:0]    Cnt,
    output logic [WIDTH-1:0] Xw,
    output logic [WIDTH-1:0] Yw,
`ifdef SIPO_PARITY_EN
    output logic             Par,
`endif
    output logic             Valid
);
    logic [WIDTH-1:0] x_nxt, y_nxt;
    logic             last;
    always_comb begin
        x_nxt = {X[WIDTH-2:0], D};
        y_nxt = {D, Y[WIDTH-1:1]};
        last  = Cnt == CW'(WIDTH - 1);
    end
    // Counter wraps explicitly so non-power-of-two widths work.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            X     <= '0;
            Y     <= '0;
            Cnt   <= '0;
            Xw    <= '0;
            Yw    <= '0;
            Valid <= 1'b0;
`ifdef SIPO_PARITY_EN
            Par   <= 1'b0;
`endif
        end else if (Clr) begin
            X     <= '0;
            Y     <= '0;
            Cnt   <= '0;
            Valid <= 1'b0;
        end else if (En) begin
            X     <= x_nxt;
            Y     <= y_nxt;
            Cnt   <= last ? '0 : Cnt + CW'(1);
            Valid <= last;
            if (last) begin
                Xw  <= x_nxt;
                Yw  <= y_nxt;
`ifdef SIPO_PARITY_EN
                Par <= ^x_nxt;
`endif
            end
        end else begin
            Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dual_sipo_shifter.sv
// tb_dual_sipo_shifter: directed checks of a WIDTH=4 instance and a WIDTH=5 streaming instance.
module tb_dual_sipo_shifter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d4 = 1'b1, en4 = 1'b1, clr4 = 1'b0;
    logic       d5 = 1'b0, en5 = 1'b0, clr5 = 1'b0;
    logic [3:0] x4, y4, xw4, yw4;
    logic [1:0] cnt4;
    logic       valid4, par4;
    logic [4:0] x5, y5, xw5, yw5;
    logic [2:0] cnt5;
    logic       valid5, par5;
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    dual_sipo_shifter #(.WIDTH(4)) dut4 (
        .Clk(clk), .Rst_n(rst_n), .D(d4), .En(en4), .Clr(clr4),
        .X(x4), .Y(y4), .Cnt(cnt4), .Xw(xw4), .Yw(yw4),
`ifdef SIPO_PARITY_EN
        .Par(par4),
`endif
        .Valid(valid4)
    );
    dual_sipo_shifter #(.WIDTH(5)) dut5 (
        .Clk(clk), .Rst_n(rst_n), .D(d5), .En(en5), .Clr(clr5),
        .X(x5), .Y(y5), .Cnt(cnt5), .Xw(xw5), .Yw(yw5),
`ifdef SIPO_PARITY_EN
        .Par(par5),
`endif
        .Valid(valid5)
    );
`ifndef SIPO_PARITY_EN
    assign par4 = 1'b0;
    assign par5 = 1'b0;
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic shift4(input logic b);
        d4 = b; en4 = 1'b1; clr4 = 1'b0;
        step();
        en4 = 1'b0;
    endtask
    task automatic chk4(input string tag, input logic [3:0] x, input logic [3:0] y, input logic [1:0] c,
                        input logic [3:0] xw, input logic [3:0] yw, input logic v);
        chk({tag, ".x"}, 32'(x4), 32'(x));
        chk({tag, ".y"}, 32'(y4), 32'(y));
        chk({tag, ".cnt"}, 32'(cnt4), 32'(c));
        chk({tag, ".xw"}, 32'(xw4), 32'(xw));
        chk({tag, ".yw"}, 32'(yw4), 32'(yw));
        chk({tag, ".valid"}, 32'(valid4), 32'(v));
    endtask
    function automatic logic [4:0] rev5(input logic [4:0] v);
        for (int i = 0; i < 5; i++) rev5[i] = v[4-i];
    endfunction
    initial begin
        logic [4:0] xm;
        logic [4:0] xwm;
        // reset held with En toggling and D=1
        for (int i = 0; i < 3; i++) begin
            en4 = ~en4;
            step();
            chk4("rst", 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0);
        end
        #2 rst_n = 1'b1;
        shift4(1'b1);
        chk4("first", 4'b0001, 4'b1000, 2'd1, 4'h0, 4'h0, 1'b0);
        clr4 = 1'b1; step(); clr4 = 1'b0;
        chk4("clr0", 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0);
        // full word 1,0,1,1
        shift4(1'b1); shift4(1'b0); shift4(1'b1);
        chk4("w1b3", 4'b0101, 4'b1010, 2'd3, 4'h0, 4'h0, 1'b0);
        shift4(1'b1);
        chk4("w1", 4'b1011, 4'b1101, 2'd0, 4'b1011, 4'b1101, 1'b1);
`ifdef SIPO_PARITY_EN
        chk("w1.par", 32'(par4), 32'd1);
`endif
        step();
        chk4("w1hold", 4'b1011, 4'b1101, 2'd0, 4'b1011, 4'b1101, 1'b0);
        // enable gap of 3 cycles between bit 2 and bit 3
        shift4(1'b1); shift4(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("gap", 4'b1110, 4'b0111, 2'd2, 4'b1011, 4'b1101, 1'b0);
        end
        shift4(1'b1);
        chk4("gapb3", 4'b1101, 4'b1011, 2'd3, 4'b1011, 4'b1101, 1'b0);
        shift4(1'b1);
        chk4("gapw", 4'b1011, 4'b1101, 2'd0, 4'b1011, 4'b1101, 1'b1);
        // clear mid-word overrides En
        shift4(1'b1); shift4(1'b1);
        chk4("pre_clr", 4'b1111, 4'b1111, 2'd2, 4'b1011, 4'b1101, 1'b0);
        d4 = 1'b1; en4 = 1'b1; clr4 = 1'b1; step(); en4 = 1'b0; clr4 = 1'b0;
        chk4("clr_mid", 4'h0, 4'h0, 2'd0, 4'b1011, 4'b1101, 1'b0);
        shift4(1'b0); shift4(1'b1); shift4(1'b1); shift4(1'b0);
        chk4("w0110", 4'b0110, 4'b0110, 2'd0, 4'b0110, 4'b0110, 1'b1);
`ifdef SIPO_PARITY_EN
        chk("w0110.par", 32'(par4), 32'd0);
`endif
        // async reset between edges after 3 bits
        shift4(1'b1); shift4(1'b0); shift4(1'b1);
        chk4("pre_arst", 4'b0101, 4'b1010, 2'd3, 4'b0110, 4'b0110, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk4("arst", 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 1'b0);
        #1 rst_n = 1'b1;
        shift4(1'b1); shift4(1'b1); shift4(1'b1); shift4(1'b0);
        chk4("w1110", 4'b1110, 4'b0111, 2'd0, 4'b1110, 4'b0111, 1'b1);
`ifdef SIPO_PARITY_EN
        chk("w1110.par", 32'(par4), 32'd1);
`endif
        // Clr on the word-completing edge suppresses the word
        shift4(1'b0); shift4(1'b0); shift4(1'b0);
        d4 = 1'b1; en4 = 1'b1; clr4 = 1'b1; step(); en4 = 1'b0; clr4 = 1'b0;
        chk4("clr_last", 4'h0, 4'h0, 2'd0, 4'b1110, 4'b0111, 1'b0);
        // WIDTH=5 streaming, alternating D starting at 1
        xm = '0; xwm = '0;
        chk("s5.reset_xw", 32'(xw5), 32'd0);
        en5 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            d5 = k[0];
            step();
            xm = {xm[3:0], k[0]};
            if (k % 5 == 0) xwm = xm;
            chk($sformatf("s5.valid%0d", k), 32'(valid5), 32'(k % 5 == 0));
            chk($sformatf("s5.inv%0d", k), 32'(y5), 32'(rev5(x5)));
            chk($sformatf("s5.x%0d", k), 32'(x5), 32'(xm));
            chk($sformatf("s5.cnt%0d", k), 32'(cnt5), 32'(k % 5));
            chk($sformatf("s5.xw%0d", k), 32'(xw5), 32'(xwm));
            chk($sformatf("s5.yw%0d", k), 32'(yw5), 32'(rev5(xwm)));
        end
        chk("s5.w3", 32'(xw5), 32'(5'b10101));
`ifdef SIPO_PARITY_EN
        chk("s5.par", 32'(par5), 32'd1);
`endif
        en5 = 1'b0;
        step();
        chk("s5.valid_end", 32'(valid5), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dual_sipo_shifter.md
Name: dual_sipo_shifter

Overview:
Parametrised two-channel serial-in/parallel-out shifter with a shared serial input D. Channel X shifts toward the MSB and channel Y shifts toward the LSB, so Y always holds the bit-reverse of X. It adds shift enable, synchronous clear, a bit counter, and a latched word output with a one-cycle valid pulse. It sits between a serial bit source and word-wide consumers in the lab datapath.

Parameters:
- WIDTH, 4, shift register width in bits; legal range 2..32.
- CW, $clog2(WIDTH), counter width; derived, not overridden.

Ports:
- Clk  in  1  system clock, rising-edge active.
- Rst_n  in  1  reset, asynchronous, active-low.
- D  in  1  serial data bit, sampled on the rising edge of Clk.
- En  in  1  shift enable.
- Clr  in  1  synchronous clear of the shift state.
- X  out  WIDTH  live left-shift register; the newest bit is at X[0].
- Y  out  WIDTH  live right-shift register; the newest bit is at Y[WIDTH-1].
- Cnt  out  CW  number of bits shifted into the current word, 0..WIDTH-1.
- Xw  out  WIDTH  last completed X word.
- Yw  out  WIDTH  last completed Y word.
- Valid  out  1  one-cycle pulse marking a new Xw/Yw.

Behaviour:
- Clock and reset: one clock (Clk); reset Rst_n is asynchronous and active-low.
- Reset values: while Rst_n=0, X, Y, Cnt, Xw, Yw and Valid are all 0. This applies immediately, including mid-word. The first edge after release behaves normally.
- Priority per rising edge: Clr > En > hold.
- When Clr=1:
  - X, Y and Cnt become 0, and Valid becomes 0.
  - Xw and Yw keep their values.
  - Clr overrides a simultaneous En, including on the word-completing edge: no word is produced.
- When En=1 and Clr=0:
  - X <= {X[WIDTH-2:0], D}.
  - Y <= {D, Y[WIDTH-1:1]}.
  - Cnt <= Cnt+1, wrapping from WIDTH-1 to 0. Wrap is explicit; WIDTH need not be a power of two.
- Word completion: on an En edge with Cnt==WIDTH-1:
  - Xw gets the new X value and Yw gets the new Y value, on the same edge.
  - Valid=1 for exactly the following cycle.
  - The live X/Y registers are not cleared. The next word overwrites them bit by bit.
- Valid=0 on every other edge, including En=0 edges. Back-to-back words with En held high produce a Valid pulse every WIDTH cycles.
- Hold: with En=0 and Clr=0, X, Y, Cnt, Xw and Yw hold their values.
- Latency: D appears in X[0] and Y[WIDTH-1] one edge after sampling. A word appears on Xw/Yw on the same edge as its last bit.
- Invariants, checkable at every cycle:
  - Y == bit-reverse(X).
  - Yw == bit-reverse(Xw).
  - Cnt < WIDTH.
- No X-propagation: all outputs are registered, with no combinational path from D to any output.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - Adds output port Par (out, 1).
  - Par is the even-parity bit (^ of the word) of each completed word.
  - Par is registered on the word-completing edge together with Xw.
  - Par resets to 0 and holds through Clr.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: Rst_n=0 with D=1 and En=1 toggling → X=Y=Xw=Yw=0, Cnt=0, Valid=0 throughout. Release, then shift 1 → X=4'b0001, Y=4'b1000, Cnt=1.
- Full word (WIDTH=4): En=1, D=1,0,1,1 on four edges → X=4'b1011, Y=4'b1101, Xw=4'b1011, Yw=4'b1101, Cnt=0, Valid high for exactly one cycle. With SIPO_PARITY_EN, Par=1.
- Enable gaps: same bits with En dropped for 3 cycles between bit 2 and bit 3 → X, Y and Cnt hold during the gap, and the final Xw=4'b1011 appears on the 4th enabled edge only.
- Clear mid-word: shift 1,1 (Cnt=2), then Clr=1 with En=1 for one edge → X=Y=0, Cnt=0, Valid=0, Xw unchanged from the previous word. Then shift 0,1,1,0 → Xw=4'b0110, Yw=4'b0110.
- Async reset mid-word: after 3 bits, pulse Rst_n low between clock edges → all outputs 0 immediately, and the next 4 bits 1,1,1,0 produce Xw=4'b1110 and Yw=4'b0111.
- Streaming with WIDTH=5: En held high for 15 cycles with alternating D starting at 1 → Valid pulses at cycles 5, 10 and 15. Xw=5'b10101, then 5'b01010, then 5'b10101. The Y==bit-reverse(X) invariant is checked every cycle.
